// File: rtl/rv32_mem_pkg.sv
// rv32_mem_pkg: shared RV32 load/store encodings and data-cache types
//   F3_*           : funct3 encodings for loads and stores
//   BLOCK_BITS     : cache line / main-memory block width
//   dcache_state_t : miss-handling FSM states
package rv32_mem_pkg;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam int BLOCK_BITS = 128;
    typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH} dcache_state_t;
endpackage

// File: rtl/dcache_ctrl_if.sv
// dcache_ctrl_if: CPU-side request bus and main-memory block bus of the data cache
//   mem_read/mem_write/funct3/address/write_data -> cache, read_data/busywait <- cache
//   mm_read/mm_write/mm_address/mm_write_data <- cache, mm_read_data/mm_busywait -> cache
//   modport master : MEM stage plus main memory (the cache's environment)
//   modport slave  : the cache controller
interface dcache_ctrl_if;
    import rv32_mem_pkg::*;
    logic                  mem_read;
    logic                  mem_write;
    logic [2:0]            funct3;
    logic [31:0]           address;
    logic [31:0]           write_data;
    logic [31:0]           read_data;
    logic                  busywait;
    logic                  mm_read;
    logic                  mm_write;
    logic [27:0]           mm_address;
    logic [BLOCK_BITS-1:0] mm_write_data;
    logic [BLOCK_BITS-1:0] mm_read_data;
    logic                  mm_busywait;
    modport master (
        output mem_read, mem_write, funct3, address, write_data, mm_read_data, mm_busywait,
        input  read_data, busywait, mm_read, mm_write, mm_address, mm_write_data
    );
    modport slave (
        input  mem_read, mem_write, funct3, address, write_data, mm_read_data, mm_busywait,
        output read_data, busywait, mm_read, mm_write, mm_address, mm_write_data
    );
endinterface

// File: rtl/dcache_line_store.sv
// dcache_line_store: valid/dirty/tag/data arrays of the direct-mapped data cache
//   clk, rst                      : clock, synchronous active-low reset (clears valid/dirty only)
//   index                         : line used for lookup, store and fill
//   valid, dirty, tag, data       : state of the indexed line
//   wr_en, wr_word, wr_be, wr_data: byte-lane store into the indexed line, marks it dirty
//   fill_en, fill_tag, fill_data  : whole-block refill, marks the line valid and clean
module dcache_line_store
    import rv32_mem_pkg::*;
#(
    parameter int INDEX_BITS = 3,
    parameter int TAG_BITS   = 32 - 4 - INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] index,
    output logic                  valid,
    output logic                  dirty,
    output logic [TAG_BITS-1:0]   tag,
    output logic [BLOCK_BITS-1:0] data,
    input  logic                  wr_en,
    input  logic [1:0]            wr_word,
    input  logic [3:0]            wr_be,
    input  logic [31:0]           wr_data,
    input  logic                  fill_en,
    input  logic [TAG_BITS-1:0]   fill_tag,
    input  logic [BLOCK_BITS-1:0] fill_data
);
    localparam int LINES = 1 << INDEX_BITS;
    logic [LINES-1:0]      valid_q, valid_d, dirty_q, dirty_d;
    logic [TAG_BITS-1:0]   tag_q [LINES];
    logic [TAG_BITS-1:0]   tag_d [LINES];
    logic [BLOCK_BITS-1:0] data_q [LINES];
    logic [BLOCK_BITS-1:0] data_d [LINES];

    assign valid = valid_q[index];
    assign dirty = dirty_q[index];
    assign tag   = tag_q[index];
    assign data  = data_q[index];

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill_en) begin
            valid_d[index] = 1'b1;
            dirty_d[index] = 1'b0;
            tag_d[index]   = fill_tag;
            data_d[index]  = fill_data;
        end else if (wr_en) begin
            dirty_d[index] = 1'b1;
            for (int b = 0; b < 4; b++)
                if (wr_be[b]) data_d[index][32*wr_word + 8*b +: 8] = wr_data[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        valid_q <= rst ? valid_d : '0;
        dirty_q <= rst ? dirty_d : '0;
        tag_q   <= tag_d;
        data_q  <= data_d;
    end
endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back write-allocate data cache with RV32 access sizing
//   clk, rst : clock, synchronous active-low reset
//   bus      : dcache_ctrl_if.slave - CPU request/response and 128-bit main-memory handshake
//   hit_count, miss_count : access statistics, present only with DCACHE_STATS_EN defined
module dcache_ctrl
    import rv32_mem_pkg::*;
#(
    parameter int INDEX_BITS  = 3,
    parameter int BLOCK_WORDS = 4,
    parameter int TAG_BITS    = 32 - 4 - INDEX_BITS
) (
    input  logic        clk,
    input  logic        rst,
    dcache_ctrl_if.slave bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int WORD_BITS = $clog2(BLOCK_WORDS);
    dcache_state_t         state_q, state_d;
    logic [TAG_BITS-1:0]   tag, line_tag;
    logic [INDEX_BITS-1:0] index;
    logic [WORD_BITS-1:0]  word;
    logic [1:0]            boff;
    logic                  line_valid, line_dirty, req, hit, wr_en, fill_en, sx;
    logic [BLOCK_BITS-1:0] line_data;
    logic [31:0]           word_data, st_data;
    logic [3:0]            st_be;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;

    assign tag   = bus.address[31 -: TAG_BITS];
    assign index = bus.address[4 +: INDEX_BITS];
    assign word  = bus.address[2 +: WORD_BITS];
    assign boff  = bus.address[1:0];

    assign req          = bus.mem_read | bus.mem_write;
    assign hit          = line_valid && line_tag == tag;
    assign bus.busywait = req && (state_q != IDLE || !hit);
    assign wr_en        = bus.mem_write && state_q == IDLE && hit;
    assign fill_en      = state_q == FETCH && !bus.mm_busywait;

    dcache_line_store #(.INDEX_BITS(INDEX_BITS), .TAG_BITS(TAG_BITS)) u_store (
        .clk      (clk),
        .rst      (rst),
        .index    (index),
        .valid    (line_valid),
        .dirty    (line_dirty),
        .tag      (line_tag),
        .data     (line_data),
        .wr_en    (wr_en),
        .wr_word  (word),
        .wr_be    (st_be),
        .wr_data  (st_data),
        .fill_en  (fill_en),
        .fill_tag (tag),
        .fill_data(bus.mm_read_data)
    );

    // Low address bits beyond the access size are ignored rather than trapped.
    assign word_data = line_data[32*word +: 32];
    assign ld_byte   = word_data[8*boff +: 8];
    assign ld_half   = word_data[16*boff[1] +: 16];
    assign sx        = !bus.funct3[2];

    // A simultaneous read+write is a store, so no load data is returned for it.
    assign bus.read_data = !bus.mem_read || bus.mem_write ? '0 :
                           bus.funct3[1:0] == F3_LB[1:0] ? {{24{sx && ld_byte[7]}}, ld_byte} :
                           bus.funct3[1:0] == F3_LH[1:0] ? {{16{sx && ld_half[15]}}, ld_half} :
                           word_data;

    assign st_be   = bus.funct3[1:0] == F3_SB[1:0] ? 4'b0001 << boff :
                     bus.funct3[1:0] == F3_SH[1:0] ? (boff[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign st_data = bus.funct3[1:0] == F3_SB[1:0] ? {4{bus.write_data[7:0]}} :
                     bus.funct3[1:0] == F3_SH[1:0] ? {2{bus.write_data[15:0]}} : bus.write_data;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (req && !hit) state_d = line_valid && line_dirty ? WRITEBACK : FETCH;
            WRITEBACK: if (!bus.mm_busywait) state_d = FETCH;
            FETCH:     if (!bus.mm_busywait) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        state_q <= rst ? state_d : IDLE;
    end

    // Main-memory outputs are pure functions of the state, so they are all zero in IDLE and after reset.
    assign bus.mm_write      = state_q == WRITEBACK;
    assign bus.mm_read       = state_q == FETCH;
    assign bus.mm_address    = state_q == WRITEBACK ? {line_tag, index} :
                               state_q == FETCH ? bus.address[31:4] : '0;
    assign bus.mm_write_data = state_q == WRITEBACK ? line_data : '0;

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;
    logic        refill_q, refill_d;

    // The retried access right after a refill hits, but it was already counted as a miss.
    always_comb begin
        refill_d     = fill_en;
        hit_count_d  = hit_count_q + 32'(state_q == IDLE && req && hit && !refill_q);
        miss_count_d = miss_count_q + 32'(state_q == IDLE && state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
            refill_q     <= 1'b0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            refill_q     <= refill_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: randomized bench for dcache_ctrl against a flat byte-memory and line-occupancy model
module tb_dcache_ctrl;
    import rv32_mem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dcache_ctrl_if bus();
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    dcache_ctrl dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count(hit_count),
        .miss_count(miss_count)
`endif
    );

    int n_pass = 0;
    int n_total = 0;
    int lat = 3;
    int cnt = 0;
    int ref_hits = 0;
    int ref_misses = 0;
    int mm_log [$];
    logic [127:0] mm_mem [512];
    logic [7:0]   ref_mem [8192];
    bit           ref_valid [8];
    bit           ref_dirty [8];
    int           ref_tag [8];

    assign bus.mm_read_data = mm_mem[bus.mm_address[8:0]];

    task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] init_word(int w);
        return (w >= 16 && w < 20) ? 32'h11111111 * (w - 15) : (32'(w) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic int acc_size(logic [2:0] f3);
        return f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(logic [2:0] f3, int a);
        int n = acc_size(f3);
        int base = a - a % n;
        logic [31:0] v = 0;
        for (int i = 0; i < n; i++) v |= 32'(ref_mem[base + i]) << (8 * i);
        if (n < 4 && !f3[2] && v[8*n-1]) v |= 32'hFFFFFFFF << (8 * n);
        return v;
    endfunction

    task automatic ref_store(logic [2:0] f3, int a, logic [31:0] wd);
        int n = acc_size(f3);
        int base = a - a % n;
        for (int i = 0; i < n; i++) ref_mem[base + i] = 8'(wd >> (8 * i));
    endtask

    function automatic logic [127:0] ref_block(int b);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = ref_mem[16*b + i];
        return r;
    endfunction

    // Main memory: holds each request for lat busy cycles, completes on the next edge.
    initial begin
        for (int b = 0; b < 512; b++)
            for (int w = 0; w < 4; w++) mm_mem[b][32*w +: 32] = init_word(4*b + w);
        bus.mm_busywait = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!(bus.mm_read || bus.mm_write)) begin
                cnt = 0;
                bus.mm_busywait = 1'b0;
            end else begin
                chk("mm_rw_excl", 128'(bus.mm_read & bus.mm_write), 128'(0));
                if (cnt < lat) begin
                    cnt++;
                    bus.mm_busywait = 1'b1;
                end else begin
                    cnt = 0;
                    bus.mm_busywait = 1'b0;
                    if (bus.mm_write) mm_mem[bus.mm_address[8:0]] = bus.mm_write_data;
                    mm_log.push_back(int'({bus.mm_write, bus.mm_address}));
                end
            end
        end
    end

    task automatic finish_access(bit is_st, logic [2:0] f3, logic [31:0] addr, logic [31:0] wd,
                                 int lat_i, int n0, string tag);
        int blk = int'(addr >> 4);
        int idx = blk % 8;
        int t = blk / 8;
        bit hit = ref_valid[idx] && ref_tag[idx] == t;
        bit wb = !hit && ref_valid[idx] && ref_dirty[idx];
        int victim = ref_tag[idx] * 8 + idx;
        int exp_stall = hit ? 0 : wb ? 2 * lat_i + 3 : lat_i + 2;
        int exp_txn = hit ? 0 : wb ? 2 : 1;
        int stall = 0;
        while (bus.busywait && stall < 200) begin
            @(negedge clk);
            #2;
            stall++;
        end
        chk({tag, ":stall"}, 128'(stall), 128'(exp_stall));
        chk({tag, ":rdata"}, 128'(bus.read_data), 128'(is_st ? 32'h0 : ref_load(f3, int'(addr))));
        chk({tag, ":txns"}, 128'(mm_log.size() - n0), 128'(exp_txn));
        if (!hit && mm_log.size() - n0 == exp_txn) begin
            if (wb) begin
                chk({tag, ":wb_addr"}, 128'(mm_log[n0]), 128'((1 << 28) | victim));
                chk({tag, ":wb_data"}, mm_mem[victim], ref_block(victim));
            end
            chk({tag, ":fill_addr"}, 128'(mm_log[n0 + exp_txn - 1]), 128'(blk));
        end
        if (hit) ref_hits++;
        else ref_misses++;
        if (!hit) begin
            ref_valid[idx] = 1'b1;
            ref_dirty[idx] = 1'b0;
            ref_tag[idx] = t;
        end
        if (is_st) begin
            ref_dirty[idx] = 1'b1;
            ref_store(f3, int'(addr), wd);
        end
    endtask

    task automatic drive(bit is_st, logic [2:0] f3, logic [31:0] addr, logic [31:0] wd);
        bus.mem_read = !is_st;
        bus.mem_write = is_st;
        bus.funct3 = f3;
        bus.address = addr;
        bus.write_data = wd;
    endtask

    task automatic access(bit is_st, logic [2:0] f3, logic [31:0] addr, logic [31:0] wd,
                          int lat_i, string tag);
        int n0 = mm_log.size();
        lat = lat_i;
        @(negedge clk);
        drive(is_st, f3, addr, wd);
        #2;
        finish_access(is_st, f3, addr, wd, lat_i, n0, tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit          st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [2:0]  ld_f3 [5];
        int          n0;
        ld_f3 = '{F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
        for (int i = 0; i < 8192; i++) ref_mem[i] = 8'(init_word(i / 4) >> (8 * (i % 4)));
        drive(1'b0, 3'd0, 32'h0, 32'h0);
        bus.mem_read = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #2;
        chk("rst_busywait", 128'(bus.busywait), 128'(0));
        chk("rst_mm_read", 128'(bus.mm_read), 128'(0));
        chk("rst_mm_write", 128'(bus.mm_write), 128'(0));
        chk("rst_mm_address", 128'(bus.mm_address), 128'(0));
        chk("rst_mm_wdata", bus.mm_write_data, 128'(0));
        chk("rst_read_data", 128'(bus.read_data), 128'(0));

        access(1'b0, F3_LW, 32'h40, 32'h0, 3, "lw_40");
        chk("plan_lw_40", 128'(bus.read_data), 128'(32'h11111111));
        access(1'b1, F3_SB, 32'h43, 32'h80, 3, "sb_43");
        access(1'b0, F3_LB, 32'h43, 32'h0, 3, "lb_43");
        chk("plan_lb_43", 128'(bus.read_data), 128'(32'hFFFFFF80));
        access(1'b0, F3_LBU, 32'h43, 32'h0, 3, "lbu_43");
        chk("plan_lbu_43", 128'(bus.read_data), 128'(32'h00000080));
        access(1'b1, F3_SH, 32'h46, 32'h1234, 3, "sh_46");
        access(1'b0, F3_LW, 32'h44, 32'h0, 3, "lw_44");
        chk("plan_lw_44", 128'(bus.read_data), 128'(32'h12342222));
        access(1'b0, F3_LW, 32'h1040, 32'h0, 3, "lw_1040");
        chk("plan_wb_block", mm_mem[4], 128'h44444444_33333333_12342222_80111111);
        access(1'b0, F3_LW, 32'h40, 32'h0, 2, "lw_40_again");

        // Reset while a fetch is outstanding; the held load has to miss again.
        n0 = mm_log.size();
        lat = 5;
        @(negedge clk);
        drive(1'b0, F3_LW, 32'h840, 32'h0);
        @(negedge clk);
        #2;
        chk("pre_rst_mm_read", 128'(bus.mm_read), 128'(1));
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #2;
        chk("post_rst_mm_read", 128'(bus.mm_read), 128'(0));
        chk("post_rst_mm_write", 128'(bus.mm_write), 128'(0));
        chk("post_rst_busywait", 128'(bus.busywait), 128'(1));
        for (int i = 0; i < 8; i++) ref_valid[i] = 1'b0;
        ref_hits = 0;
        ref_misses = 0;
        finish_access(1'b0, F3_LW, 32'h840, 32'h0, 5, n0, "lw_840_after_rst");

        for (int i = 0; i < 300; i++) begin
            st = 1'($urandom_range(0, 1));
            f3 = st ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
            a = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 7)) << 4) | 32'($urandom_range(0, 15));
            access(st, f3, a, $urandom, $urandom_range(1, 3), "rnd");
        end
        @(negedge clk);
        drive(1'b0, 3'd0, 32'h0, 32'h0);
        bus.mem_read = 1'b0;
        @(negedge clk);
`ifdef DCACHE_STATS_EN
        chk("hit_count", 128'(hit_count), 128'(ref_hits));
        chk("miss_count", 128'(miss_count), 128'(ref_misses));
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache between the MEM stage and main data memory.
- Responder side of the MEM-stage memory interface: it drives `busywait`, which stalls the MEM/WB register and the earlier pipeline registers.
- It is the initiator toward main memory using a 128-bit block handshake.
- It performs RV32 byte, half and word access selection, plus load sign/zero extension.

Parameters:
- INDEX_BITS, 3, log2 of line count (8 lines).
- BLOCK_WORDS, 4, fixed 32-bit words per line (block = 128 bits; not to be changed).
- TAG_BITS, 32-4-INDEX_BITS, derived tag width.

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst  input  1  reset; synchronous, active-low (rst==0 sampled at posedge resets).
- mem_read  input  1  CPU load request.
- mem_write  input  1  CPU store request.
- funct3  input  3  RV32 load/store funct3 (LB, LH, LW, LBU, LHU, SB, SH, SW).
- address  input  32  CPU byte address (ALU result).
- write_data  input  32  store data (rs2).
- read_data  output  32  extended load data.
- busywait  output  1  stall request to the pipeline.
- mm_read  output  1  main-memory block read request.
- mm_write  output  1  main-memory block write request.
- mm_address  output  28  block address (address[31:4]).
- mm_write_data  output  128  victim block.
- mm_read_data  input  128  fetched block.
- mm_busywait  input  1  main memory busy; transfer completes on the first posedge where it is low while a request is held.

Behaviour:
- Per-line state: valid, dirty, tag, 128-bit data.
- Address split: tag = address[31:4+INDEX_BITS], index = address[3+INDEX_BITS:4], word = address[3:2], byte = address[1:0].
- Hit is combinational: valid[index] and tag match.
- busywait is combinational:
  - 1 when (mem_read|mem_write) and (state!=IDLE or !hit).
  - 0 otherwise.
  - 0 when there is no request.
- Hit latency: zero stall cycles.
  - Load data is valid combinationally in the same cycle.
  - A store hit writes the selected byte lanes and sets dirty at that posedge.
- Alignment:
  - LH/SH use byte[1]; LB/SB use byte[1:0].
  - Misaligned accesses are not trapped: low bits beyond the access size are ignored.
- Load extension:
  - LB/LH sign-extend; LBU/LHU zero-extend; LW is passed through.
  - read_data is 0 when mem_read==0.
- If mem_read and mem_write are both 1, the access is treated as a store.
- FSM states: IDLE, WRITEBACK, FETCH.
  - IDLE → WRITEBACK: request, miss, victim valid and dirty.
  - IDLE → FETCH: request, miss, victim clean or invalid.
  - WRITEBACK:
    - Drive mm_write=1, mm_address={victim tag, index}, mm_write_data=victim block.
    - Hold until mm_busywait==0 at a posedge, then go to FETCH.
  - FETCH:
    - Drive mm_read=1, mm_address=address[31:4].
    - On the posedge with mm_busywait==0: line data=mm_read_data, tag updated, valid=1, dirty=0; go to IDLE.
  - Back in IDLE, the retried access hits, so busywait falls the cycle after the fill.
- The CPU holds the request stable while busywait=1; inputs are not re-latched mid-miss.
- mm_read/mm_write are never both 1. Both are 0 in IDLE.
- Reset (rst==0 at posedge):
  - All valid/dirty cleared, state=IDLE.
  - mm_read=0, mm_write=0, mm_address=0, mm_write_data=0.
  - busywait follows its combinational rule (1 on the first request after reset, since no line is valid).
  - An in-flight main-memory transfer is abandoned, with no writeback of dirty data.
  - Data arrays need not be cleared.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- Defined:
  - Adds outputs hit_count[31:0] and miss_count[31:0], both reset to 0.
  - hit_count increments once per access that is a hit in IDLE.
  - miss_count increments once on each IDLE→WRITEBACK/FETCH transition.
  - Both counters wrap at 2^32.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (rv32_mem_pkg):
  - funct3 constants F3_LB=000, F3_LH=001, F3_LW=010, F3_LBU=100, F3_LHU=101, F3_SB=000, F3_SH=001, F3_SW=010.
  - dcache_state_t enum {IDLE, WRITEBACK, FETCH}.
  - BLOCK_BITS=128.
- One natural sub-module: dcache_line_store. It holds the valid/dirty/tag/data arrays, plus a byte-lane write port and a full-block fill port.
- The FSM and extension logic stay in dcache_ctrl.

Test Plan:
- Reset, then LW 0x0000_0040 with memory returning block 0x44444444_33333333_22222222_11111111 after 3 busy cycles → mm_read for mm_address 0x0000004; busywait high 5 cycles; read_data=0x11111111.
- SB 0x80 to addr 0x0000_0043, then LB 0x43 and LBU 0x43 → no stall on the second and third accesses; read_data=0xFFFFFF80, then 0x00000080.
- SH 0x1234 to 0x0000_0046, then LW 0x44 → read_data=0x1234_2222 (upper half replaced, other lanes unchanged).
- Dirty line index 4, then LW 0x0000_1040 (same index, new tag) → mm_write of the old block to 0x0000004 precedes mm_read of 0x0000104; dirty=0 after the fill.
- rst=0 asserted during FETCH → next cycle mm_read=0, state IDLE; the same LW then misses again.
- With DCACHE_STATS_EN: 2 misses + 3 hits → hit_count=3, miss_count=2.
